// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction fetch stage for picoMIPS.
// The stage requests one instruction from program memory using a req/ack
// handshake. It latches the returned word into the instruction register and
// presents it to the decoder for a single EXEC cycle. The decoder's PC
// controls sampled in that cycle select the next program counter.
module pc_fetch #(
    parameter int Psize = 6,
    parameter int Isize = 24,
    parameter int Csize = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             run,
    output logic             mem_req,
    output logic [Psize-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [Isize-1:0] mem_rdata,
    output logic [Isize-1:0] instr,
    output logic [5:0]       opcode,
    output logic             instr_valid,
    input  logic             PCincr,
    input  logic             PCabsbranch,
    input  logic             PCrelbranch,
    input  logic [Psize-1:0] Branchaddr,
    output logic [Psize-1:0] PCout,
    output logic [Csize-1:0] icount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [Psize-1:0]   pc;
    logic [Psize-1:0]   pc_next;
    logic [Isize-1:0]   ir;
    logic [Isize-1:0]   ir_next;
    logic [Csize-1:0]   count;
    logic [Csize-1:0]   count_next;

    // State, PC, instruction register and retired count; reset clears all at once
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            count <= count_next;
        end
    end

    // Next state plus the PC/IR/count updates, decoder inputs only matter in EXEC
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (PCabsbranch) begin
                    pc_next = Branchaddr;
                end else if (PCrelbranch) begin
                    pc_next = pc + Branchaddr;
                end else if (PCincr) begin
                    pc_next = pc + Psize'(1);
                end
                count_next = count + Csize'(1);
                state_next = run ? FETCH : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers, so mem_req is glitch-free
    always_comb begin
        mem_req     = (state == FETCH);
        instr_valid = (state == EXEC);
        mem_addr    = pc;
        PCout       = pc;
        instr       = ir;
        opcode      = ir[Isize-1 -: 6];
        icount      = count;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed test of the fetch stage. A linear stimulus sequence
// is checked against hand-computed values.
module tb_pc_fetch;

    logic        clk;
    logic        nReset;
    logic        run;
    logic        mem_req;
    logic [5:0]  mem_addr;
    logic        mem_ack;
    logic [23:0] mem_rdata;
    logic [23:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        PCincr;
    logic        PCabsbranch;
    logic        PCrelbranch;
    logic [5:0]  Branchaddr;
    logic [5:0]  PCout;
    logic [15:0] icount;

    int total;
    int bad;

    pc_fetch #(.Psize(6), .Isize(24), .Csize(16)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .PCincr      (PCincr),
        .PCabsbranch (PCabsbranch),
        .PCrelbranch (PCrelbranch),
        .Branchaddr  (Branchaddr),
        .PCout       (PCout),
        .icount      (icount)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic abs, input logic rel, input logic incr,
                                 input logic [5:0] baddr);
        PCabsbranch = abs;
        PCrelbranch = rel;
        PCincr      = incr;
        Branchaddr  = baddr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // From FETCH: ack one word, drive the decoder during EXEC, and land back in FETCH
    task automatic execWith(input logic abs, input logic rel, input logic incr,
                            input logic [5:0] baddr);
        mem_ack   = 1'b1;
        mem_rdata = 24'h000123;
        stepClock();
        mem_ack = 1'b0;
        applyStimulus(abs, rel, incr, baddr);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        nReset    = 1'b0;
        run       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 24'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00);

        // Reset held for three cycles with run high
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        end
        checkOutput("rst_pc", 32'(PCout), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_instr", 32'(instr), 32'd0);
        checkOutput("rst_opcode", 32'(opcode), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_icount", 32'(icount), 32'd0);

        nReset = 1'b1;
        stepClock();
        checkOutput("first_req", 32'(mem_req), 32'd1);
        checkOutput("first_addr", 32'(mem_addr), 32'd0);

        // Sequential zero-wait fetches with increment
        for (int i = 0; i < 4; i++) begin
            checkOutput("seq_fetch_req", 32'(mem_req), 32'd1);
            checkOutput("seq_fetch_addr", 32'(mem_addr), 32'(i));
            checkOutput("seq_fetch_valid", 32'(instr_valid), 32'd0);
            mem_ack   = 1'b1;
            mem_rdata = 24'h100000 + 24'(i);
            applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
            stepClock();
            mem_rdata = 24'hFFFFFF;
            checkOutput("seq_exec_valid", 32'(instr_valid), 32'd1);
            checkOutput("seq_exec_req", 32'(mem_req), 32'd0);
            checkOutput("seq_exec_instr", 32'(instr), 32'h100000 + 32'(i));
            stepClock();
        end
        mem_ack = 1'b0;
        checkOutput("seq_icount", 32'(icount), 32'd4);
        checkOutput("seq_next_addr", 32'(mem_addr), 32'd4);

        // Jump to 63, then increment wraps to 0
        execWith(1'b1, 1'b0, 1'b0, 6'd63);
        checkOutput("wrap_at63", 32'(mem_addr), 32'd63);
        execWith(1'b0, 1'b0, 1'b1, 6'd0);
        checkOutput("wrap_to0", 32'(mem_addr), 32'd0);

        // Three wait cycles before ack
        mem_ack   = 1'b0;
        mem_rdata = 24'hABCDEF;
        for (int i = 0; i < 3; i++) begin
            checkOutput("wait_req", 32'(mem_req), 32'd1);
            checkOutput("wait_addr", 32'(mem_addr), 32'd0);
            stepClock();
        end
        checkOutput("wait_req4", 32'(mem_req), 32'd1);
        checkOutput("wait_addr4", 32'(mem_addr), 32'd0);
        mem_ack = 1'b1;
        stepClock();
        mem_ack = 1'b0;
        checkOutput("wait_instr", 32'(instr), 32'hABCDEF);
        checkOutput("wait_opcode", 32'(opcode), 32'h2A);
        checkOutput("wait_valid", 32'(instr_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd10);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("wait_valid_off", 32'(instr_valid), 32'd0);
        checkOutput("at_pc10", 32'(mem_addr), 32'd10);
        checkOutput("icount_7", 32'(icount), 32'd7);

        // Branches from PC=10
        execWith(1'b0, 1'b1, 1'b0, 6'h3E);
        checkOutput("rel_minus2", 32'(mem_addr), 32'd8);
        execWith(1'b1, 1'b0, 1'b0, 6'd10);
        execWith(1'b1, 1'b0, 1'b0, 6'd5);
        checkOutput("abs_5", 32'(mem_addr), 32'd5);
        execWith(1'b1, 1'b0, 1'b0, 6'd10);
        execWith(1'b1, 1'b1, 1'b1, 6'd20);
        checkOutput("all_prio", 32'(mem_addr), 32'd20);
        execWith(1'b1, 1'b0, 1'b0, 6'd10);
        execWith(1'b0, 1'b0, 1'b0, 6'd33);
        checkOutput("hold_10", 32'(mem_addr), 32'd10);
        checkOutput("icount_14", 32'(icount), 32'd14);

        // Dropping run mid-fetch lets the instruction complete
        run     = 1'b0;
        mem_ack = 1'b0;
        stepClock();
        checkOutput("drop_still_fetch", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        stepClock();
        mem_ack = 1'b0;
        checkOutput("drop_exec", 32'(instr_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 6'h00);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("drop_idle_req", 32'(mem_req), 32'd0);
        checkOutput("drop_idle_valid", 32'(instr_valid), 32'd0);
        checkOutput("drop_pc", 32'(PCout), 32'd11);
        mem_ack = 1'b1;
        stepClock();
        mem_ack = 1'b0;
        checkOutput("idle_ack_ignored", 32'(mem_req), 32'd0);
        checkOutput("icount_15", 32'(icount), 32'd15);
        run = 1'b1;
        stepClock();
        checkOutput("resume_req", 32'(mem_req), 32'd1);
        checkOutput("resume_addr", 32'(mem_addr), 32'd11);

        // Asynchronous reset mid-fetch, then a late ack is ignored
        #2;
        nReset = 1'b0;
        #1;
        checkOutput("async_pc", 32'(PCout), 32'd0);
        checkOutput("async_req", 32'(mem_req), 32'd0);
        checkOutput("async_icount", 32'(icount), 32'd0);
        checkOutput("async_instr", 32'(instr), 32'd0);
        run       = 1'b0;
        nReset    = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 24'h123456;
        stepClock();
        mem_ack = 1'b0;
        checkOutput("late_ack_instr", 32'(instr), 32'd0);
        checkOutput("late_ack_valid", 32'(instr_valid), 32'd0);
        checkOutput("late_ack_req", 32'(mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program counter and instruction fetch stage for picoMIPS, directly upstream of the instruction decoder. Holds the PC and requests instructions from program memory over a req/ack handshake. Latches each returned word into an instruction register and presents it to the decoder for one execute cycle. Takes the decoder's PCincr/PCabsbranch/PCrelbranch in that cycle to form the next PC.

## Interface
Parameters:
- Psize, 6: PC / program address width.
- Isize, 24: instruction width; opcode is instr[Isize-1:Isize-6].
- Csize, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- nReset  in  1  reset; asynchronous, active-low.
- run  in  1  fetch enable; 0 parks the stage in IDLE after the current instruction.
- mem_req  out  1  program memory read request.
- mem_addr  out  Psize  read address (= PCout).
- mem_ack  in  1  memory read data valid this cycle.
- mem_rdata  in  Isize  read data.
- instr  out  Isize  instruction register.
- opcode  out  6  instr[Isize-1:Isize-6], to decoder.
- instr_valid  out  1  high in EXEC only; decoder outputs are consumed this cycle.
- PCincr, PCabsbranch, PCrelbranch  in  1 each  from decoder.
- Branchaddr  in  Psize  absolute target or signed relative offset (immediate field).
- PCout  out  Psize  program counter.
- icount  out  Csize  retired-instruction count.

## Operation
- States: IDLE, FETCH, EXEC. The state is registered, and mem_req = (state==FETCH), so mem_req is glitch-free.
- IDLE: mem_req=0, instr_valid=0. Moves to FETCH on a clock edge with run=1; otherwise stays.
- FETCH: mem_req=1, mem_addr=PCout, held stable until ack.
  - On an edge with mem_ack=1: instr <= mem_rdata and the state moves to EXEC.
  - Otherwise the stage waits with no timeout.
- EXEC: instr_valid=1 for exactly one cycle. On the closing edge:
  - The PC updates by priority. PCabsbranch: PC <= Branchaddr. Else PCrelbranch: PC <= PC + Branchaddr, both Psize bits, two's-complement, modulo 2^Psize. Else PCincr: PC <= PC + 1, modulo 2^Psize. Else PC holds, and the same address is refetched.
  - icount <= icount + 1, wrapping at 2^Csize.
  - The next state is FETCH if run=1, else IDLE.
- mem_ack outside FETCH is ignored, and instr is unchanged.
- instr holds its value outside the FETCH→EXEC load edge.
- Decoder inputs are sampled only in EXEC and ignored in IDLE and FETCH.

## Timing
- Reset values: PCout=0, mem_addr=0, mem_req=0, instr=0, opcode=0, instr_valid=0, icount=0, state=IDLE.
- Reset asserted mid-operation (any state, including FETCH with mem_req high) clears everything immediately, without waiting for a clock edge. An ack arriving later is ignored.
- First request: mem_req rises after the first clock edge with nReset=1 and run=1.
- Zero-wait memory (mem_ack high in the first FETCH cycle) gives a 2-cycle instruction period, which is the minimum. Each wait cycle adds 1.
- A branch target appears on mem_addr in the cycle after EXEC; no delay slot.
- Dropping run during FETCH does not abort the fetch. The instruction completes its EXEC, then the stage goes to IDLE.

## Test plan
- Reset/idle: hold nReset=0 for 3 cycles with run=1. Check all outputs are 0 and mem_req stays 0. Release reset: mem_req=1 and mem_addr=0 one edge later.
- Sequential, zero-wait: ack every request, decoder PCincr=1. Expect mem_addr 0,1,2,3 on every 2nd cycle, instr_valid pulsing 1 of every 2 cycles, icount=4 after 4 EXECs. Also run PC=63 with incr: wraps to 0.
- Wait states: delay mem_ack by 3 cycles with mem_rdata=24'hABCDEF. Expect mem_req held 4 cycles with a constant address, then instr=24'hABCDEF, opcode=6'h2A, and instr_valid one cycle.
- Branches at PC=10:
  - PCrelbranch with Branchaddr=6'h3E (-2): next mem_addr=8.
  - PCabsbranch with Branchaddr=5: next 5.
  - PCabsbranch+PCrelbranch+PCincr together with Branchaddr=20: next 20.
  - All zero: next 10.
- Run/reset interruption:
  - run=0 during FETCH: the fetch completes, EXEC occurs, then IDLE with mem_req=0. run=1 again resumes at the updated PC.
  - nReset pulsed low mid-FETCH: PCout=0 and mem_req=0 immediately; a following mem_ack is ignored.
